control_unit: RTL and testbench

- Multicycle control FSM that drives the datapath control inputs of `cpu`: register-file addresses and write enable, immediate, mux selects, ALU operation, and data-memory write enable.
- Accepts one 32-bit RV64 instruction per valid/ready handshake.
- Decodes the instruction and sequences it through DECODE, EXECUTE, MEMORY and WRITEBACK.
- Sits between the instruction source (fetch stage or bench) and the `cpu` datapath.

---
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the `cpu` datapath.
// Accepts one 32-bit RV64 instruction per valid/ready handshake while idle and
// steps it through DECODE, EXECUTE, MEMORY and WRITEBACK as needed.
// Ports:
//   cu_clk, cu_rst        clock, synchronous active-high reset
//   cu_instruction        instruction word, latched on handshake
//   cu_instr_valid/ready  instruction handshake (ready only in IDLE)
//   cu_alu_zero           datapath ALU zero flag (beq resolution)
//   cu_rf_*               register-file read/write addresses and write strobe
//   cu_immediate          sign-extended immediate, WORDSIZE bits
//   cu_mux_0/1/2_sel      ALU A source, ALU B source, writeback source
//   cu_alu_operation      000 add, 001 sub, 010 and, 011 or
//   cu_dm_write_en        data-memory write strobe
//   cu_branch_taken       beq taken pulse
//   cu_done, cu_illegal   end-of-instruction / unsupported-encoding pulses
module control_unit #(
    parameter int WORDSIZE = 64
) (
    input  logic                cu_clk,
    input  logic                cu_rst,
    input  logic [31:0]         cu_instruction,
    input  logic                cu_instr_valid,
    output logic                cu_instr_ready,
    input  logic                cu_alu_zero,
    output logic [4:0]          cu_rf_addr_a,
    output logic [4:0]          cu_rf_addr_b,
    output logic [4:0]          cu_rf_write_addr,
    output logic                cu_rf_write_en,
    output logic [WORDSIZE-1:0] cu_immediate,
    output logic                cu_mux_0_sel,
    output logic                cu_mux_1_sel,
    output logic                cu_mux_2_sel,
    output logic [2:0]          cu_alu_operation,
    output logic                cu_dm_write_en,
    output logic                cu_branch_taken,
    output logic                cu_done,
    output logic                cu_illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    state_t      state;
    logic [31:0] instr;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_load, is_store, is_addi, is_rtype, is_beq, is_legal;
    logic [2:0] alu_op;
    logic [WORDSIZE-1:0] imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Instruction classification and per-class ALU op / immediate.
    always_comb begin
        is_load  = (opcode == 7'b0000011) && (funct3 == 3'b010 || funct3 == 3'b011);
        is_store = (opcode == 7'b0100011) && (funct3 == 3'b010 || funct3 == 3'b011);
        is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_beq   = (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_rtype = 1'b0;
        alu_op   = 3'b000;
        if (opcode == 7'b0110011) begin
            if (funct7 == 7'b0000000) begin
                unique case (funct3)
                    3'b000:  begin is_rtype = 1'b1; alu_op = 3'b000; end
                    3'b111:  begin is_rtype = 1'b1; alu_op = 3'b010; end
                    3'b110:  begin is_rtype = 1'b1; alu_op = 3'b011; end
                    default: is_rtype = 1'b0;
                endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                is_rtype = 1'b1;
                alu_op   = 3'b001;
            end
        end
        if (is_beq) begin
            alu_op = 3'b001;
        end
        is_legal = is_load | is_store | is_addi | is_rtype | is_beq;

        imm = '0;
        if (is_load || is_addi) begin
            imm = {{(WORDSIZE-12){instr[31]}}, instr[31:20]};
        end else if (is_store) begin
            imm = {{(WORDSIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
        end else if (is_beq) begin
            imm = {{(WORDSIZE-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
        end
    end

    always_ff @(posedge cu_clk) begin
        if (cu_rst) begin
            state <= S_IDLE;
            instr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cu_instr_valid) begin
                        instr <= cu_instruction;
                        state <= S_DECODE;
                    end
                end
                S_DECODE:    state <= is_legal ? S_EXECUTE : S_IDLE;
                S_EXECUTE: begin
                    if (is_load || is_store) state <= S_MEMORY;
                    else if (is_beq)         state <= S_IDLE;
                    else                     state <= S_WRITEBACK;
                end
                S_MEMORY:    state <= is_store ? S_IDLE : S_WRITEBACK;
                S_WRITEBACK: state <= S_IDLE;
                default:     state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs from state and the latched word; only branch_taken
    // looks at an input (the ALU zero flag) during EXECUTE.
    always_comb begin
        cu_instr_ready   = 1'b0;
        cu_rf_addr_a     = '0;
        cu_rf_addr_b     = '0;
        cu_rf_write_addr = '0;
        cu_rf_write_en   = 1'b0;
        cu_immediate     = '0;
        cu_mux_0_sel     = 1'b0;
        cu_mux_1_sel     = 1'b0;
        cu_mux_2_sel     = 1'b0;
        cu_alu_operation = '0;
        cu_dm_write_en   = 1'b0;
        cu_branch_taken  = 1'b0;
        cu_done          = 1'b0;
        cu_illegal       = 1'b0;

        if (state == S_IDLE) begin
            cu_instr_ready = 1'b1;
        end else begin
            cu_rf_addr_a     = instr[19:15];
            cu_rf_addr_b     = instr[24:20];
            cu_rf_write_addr = instr[11:7];
            cu_immediate     = imm;
        end

        if (state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK) begin
            cu_mux_1_sel     = is_rtype | is_beq;
            cu_alu_operation = alu_op;
        end

        unique case (state)
            S_DECODE: cu_illegal = ~is_legal;
            S_EXECUTE: begin
                if (is_beq) begin
                    cu_branch_taken = cu_alu_zero;
                    cu_done         = 1'b1;
                end
            end
            S_MEMORY: begin
                if (is_store) begin
                    cu_dm_write_en = 1'b1;
                    cu_done        = 1'b1;
                end
            end
            S_WRITEBACK: begin
                cu_mux_2_sel   = is_load;
                cu_rf_write_en = (instr[11:7] != 5'd0);
                cu_done        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit.
// A transaction-level model classifies each word from its fields and predicts,
// per cycle after the handshake, every control output of the unit.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_zero;
    logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
    logic        rf_write_en;
    logic [63:0] immediate;
    logic        mux_0_sel, mux_1_sel, mux_2_sel;
    logic [2:0]  alu_operation;
    logic        dm_write_en, branch_taken, done, illegal;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    control_unit #(.WORDSIZE(64)) dut (
        .cu_clk           (clk),
        .cu_rst           (rst),
        .cu_instruction   (instruction),
        .cu_instr_valid   (instr_valid),
        .cu_instr_ready   (instr_ready),
        .cu_alu_zero      (alu_zero),
        .cu_rf_addr_a     (rf_addr_a),
        .cu_rf_addr_b     (rf_addr_b),
        .cu_rf_write_addr (rf_write_addr),
        .cu_rf_write_en   (rf_write_en),
        .cu_immediate     (immediate),
        .cu_mux_0_sel     (mux_0_sel),
        .cu_mux_1_sel     (mux_1_sel),
        .cu_mux_2_sel     (mux_2_sel),
        .cu_alu_operation (alu_operation),
        .cu_dm_write_en   (dm_write_en),
        .cu_branch_taken  (branch_taken),
        .cu_done          (done),
        .cu_illegal       (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 illegal, 1 load, 2 store, 3 addi, 4 R-type, 5 beq
    function automatic int classify(input logic [31:0] w, output logic [2:0] op);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        op  = 3'd0;
        if (opc == 7'h03 && (f3 == 3'd2 || f3 == 3'd3)) return 1;
        if (opc == 7'h23 && (f3 == 3'd2 || f3 == 3'd3)) return 2;
        if (opc == 7'h13 && f3 == 3'd0) return 3;
        if (opc == 7'h63 && f3 == 3'd0) begin op = 3'd1; return 5; end
        if (opc == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0) begin op = 3'd0; return 4; end
            if (f7 == 7'h20 && f3 == 3'd0) begin op = 3'd1; return 4; end
            if (f7 == 7'h00 && f3 == 3'd7) begin op = 3'd2; return 4; end
            if (f7 == 7'h00 && f3 == 3'd6) begin op = 3'd3; return 4; end
        end
        return 0;
    endfunction

    function automatic logic [63:0] model_imm(input logic [31:0] w, input int kind);
        logic [11:0] i12;
        logic [12:0] b13;
        case (kind)
            1, 3: begin i12 = w[31:20]; return {{52{i12[11]}}, i12}; end
            2:    begin i12 = {w[31:25], w[11:7]}; return {{52{i12[11]}}, i12}; end
            5:    begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return {{51{b13[12]}}, b13}; end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, instr_ready, 1);
        check({tag, "_imm"}, immediate, 0);
        check({tag, "_outs"},
              {rf_addr_a, rf_addr_b, rf_write_addr, rf_write_en, mux_0_sel, mux_1_sel,
               mux_2_sel, alu_operation, dm_write_en, branch_taken, done, illegal}, 0);
    endtask

    task automatic run_instr(input logic [31:0] w, input logic zero);
        int         kind, n;
        logic [2:0] op;
        logic       writes;
        kind   = classify(w, op);
        writes = (kind == 1 || kind == 3 || kind == 4);
        case (kind)
            0: n = 1;
            1: n = 4;
            5: n = 2;
            default: n = 3;
        endcase
        check_idle("idle");
        instr_valid = 1'b1;
        instruction = w;
        alu_zero    = zero;
        tick();
        for (int k = 1; k <= n; k++) begin
            // Anything on the input side now must be ignored.
            instr_valid = 1'($urandom);
            instruction = $urandom;
            #1;
            check("ready", instr_ready, 0);
            if (kind != 0) begin
                check("addr_a", rf_addr_a, w[19:15]);
                check("addr_b", rf_addr_b, w[24:20]);
                check("wr_addr", rf_write_addr, w[11:7]);
                check("imm", immediate, model_imm(w, kind));
            end
            check("done", done, (k == n && kind != 0));
            check("illegal", illegal, (k == n && kind == 0));
            check("dm_we", dm_write_en, (kind == 2 && k == 3));
            check("rf_we", rf_write_en, (k == n && writes && w[11:7] != 5'd0));
            check("mux_0", mux_0_sel, 0);
            check("branch", branch_taken, (kind == 5 && k == 2 && zero));
            if (k >= 2) begin
                check("alu_op", alu_operation, op);
                check("mux_1", mux_1_sel, (kind == 4 || kind == 5));
            end
            if (k == n && writes) check("mux_2", mux_2_sel, (kind == 1));
            if (k == n) instr_valid = 1'b0;
            tick();
        end
    endtask

    function automatic logic [31:0] random_word();
        logic [4:0] rs1, rs2, rd;
        logic [2:0] f3;
        logic [6:0] f7;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom);
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: begin
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(2 + $urandom_range(0, 1));
                return {12'($urandom), rs1, f3, rd, 7'h03};
            end
            2: begin
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(2 + $urandom_range(0, 1));
                return {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'h23};
            end
            3: begin
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
                return {12'($urandom), rs1, f3, rd, 7'h13};
            end
            4: begin
                case ($urandom_range(0, 4))
                    0: begin f7 = 7'h00; f3 = 3'd0; end
                    1: begin f7 = 7'h20; f3 = 3'd0; end
                    2: begin f7 = 7'h00; f3 = 3'd7; end
                    3: begin f7 = 7'h00; f3 = 3'd6; end
                    default: begin f7 = 7'($urandom); f3 = 3'($urandom); end
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            default: begin
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
                return {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'h63};
            end
        endcase
    endfunction

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        alu_zero    = 1'b0;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        run_instr(32'h0053A103, 1'b0); // lw x2,5(x7)
        run_instr(32'hFE51AC23, 1'b0); // sw x5,-8(x3)
        run_instr(32'h40628233, 1'b1); // sub x4,x5,x6
        run_instr(32'h00100013, 1'b0); // addi x0,x0,1
        run_instr(32'h00208463, 1'b1); // beq taken
        run_instr(32'h00208463, 1'b0); // beq not taken
        run_instr(32'hFFFFFFFF, 1'b0); // illegal

        // Reset during MEMORY of a load: writeback must never happen.
        instr_valid = 1'b1;
        instruction = 32'h0053A103;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check("rst_mem_rf_we", rf_write_en, 0);
        check("rst_mem_ready", instr_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_after_ready", instr_ready, 1);
        check("rst_after_rf_we", rf_write_en, 0);
        tick();
        check("rst_later_rf_we", rf_write_en, 0);
        check_idle("rst_idle");

        for (int t = 0; t < 200; t++) begin
            run_instr(random_word(), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
